// File: rtl/dcb_alloc.sv
// dcb_alloc: switch allocator that drives the data crossbar configuration.
// Each input raises a one-hot request for one output; every output has its
// own round-robin arbiter and holds the winning input (wormhole lock) until
// that input transfers its tail flit.
//
// Ports:
//   clk    - single clock for all state
//   rst_n  - asynchronous active-low reset
//   req    - req[j][i]=1: input j requests output i (one-hot or zero per input)
//   fire   - a flit of input j moves through the crossbar this cycle
//   eof    - qualifies fire: that flit is the tail flit
//   cfg    - crossbar configuration, cfg[i][j]=1 connects input j to output i
//   gnt    - input j currently owns some output (OR of cfg column j)
//   err    - sticky protocol-error flag, cleared only by reset
module dcb_alloc #(
  parameter int NN = 5,
  parameter int MN = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NN-1:0][MN-1:0]  req,
  input  logic [NN-1:0]          fire,
  input  logic [NN-1:0]          eof,
  output logic [MN-1:0][NN-1:0]  cfg,
  output logic [NN-1:0]          gnt,
  output logic                   err
);

  localparam int PW = (NN > 1) ? $clog2(NN) : 1;

  typedef enum logic {IDLE, BUSY} ost_t;

  ost_t                  st_q  [MN];
  ost_t                  st_d  [MN];
  logic [PW-1:0]         ptr_q [MN];
  logic [PW-1:0]         ptr_d [MN];
  logic [MN-1:0][NN-1:0] cfg_d;
  logic [NN-1:0]         gnt_d;
  logic [NN-1:0]         valid;
  logic [NN-1:0]         tail;
  logic                  err_d;

  // An input is eligible only while its request vector is zero or one-hot.
  always_comb begin
    valid = '0;
    for (int unsigned j = 0; j < NN; j++) begin
      valid[j] = ((req[j] & (req[j] - MN'(1))) == '0);
    end
  end

  // Tail transfers only count for inputs that actually own an output.
  assign tail = fire & eof & gnt;

  always_comb begin
    logic [NN-1:0] cand;
    logic [NN-1:0] winv;
    logic          found;
    int unsigned   nxt;

    cfg_d = cfg;
    cand  = '0;
    winv  = '0;
    found = 1'b0;
    nxt   = 0;
    for (int unsigned i = 0; i < MN; i++) begin
      st_d[i]  = st_q[i];
      ptr_d[i] = ptr_q[i];
      cand     = '0;
      winv     = '0;
      found    = 1'b0;
      nxt      = 0;
      case (st_q[i])
        IDLE: begin
          for (int unsigned j = 0; j < NN; j++) begin
            cand[j] = req[j][i] & ~gnt[j] & valid[j];
          end
          // Rotating priority as two linear passes: first j >= ptr, then
          // wrap around to j < ptr.
          for (int unsigned j = 0; j < NN; j++) begin
            if (!found && cand[j] && (j >= 32'(ptr_q[i]))) begin
              found   = 1'b1;
              winv[j] = 1'b1;
              nxt     = j + 1;
            end
          end
          for (int unsigned j = 0; j < NN; j++) begin
            if (!found && cand[j] && (j < 32'(ptr_q[i]))) begin
              found   = 1'b1;
              winv[j] = 1'b1;
              nxt     = j + 1;
            end
          end
          if (found) begin
            cfg_d[i] = winv;
            st_d[i]  = BUSY;
            ptr_d[i] = (nxt >= NN) ? '0 : PW'(nxt);
          end
        end
        BUSY: begin
          // Release only; re-arbitration waits for the next cycle in IDLE.
          if ((cfg[i] & tail) != '0) begin
            cfg_d[i] = '0;
            st_d[i]  = IDLE;
          end
        end
        default: begin
          cfg_d[i] = '0;
          st_d[i]  = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    gnt_d = '0;
    for (int unsigned i = 0; i < MN; i++) begin
      gnt_d = gnt_d | cfg_d[i];
    end
  end

  assign err_d = err | (|(fire & ~gnt)) | (|(~valid));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg <= '0;
      gnt <= '0;
      err <= 1'b0;
      for (int unsigned i = 0; i < MN; i++) begin
        st_q[i]  <= IDLE;
        ptr_q[i] <= '0;
      end
    end else begin
      cfg <= cfg_d;
      gnt <= gnt_d;
      err <= err_d;
      for (int unsigned i = 0; i < MN; i++) begin
        st_q[i]  <= st_d[i];
        ptr_q[i] <= ptr_d[i];
      end
    end
  end

endmodule

// File: tb/tb_dcb_alloc.sv
// Directed bench for dcb_alloc (NN=MN=5) with hand-computed expectations.
module tb_dcb_alloc;

  logic             clk;
  logic             rst_n;
  logic [4:0][4:0]  req;
  logic [4:0]       fire;
  logic [4:0]       eof;
  logic [4:0][4:0]  cfg;
  logic [4:0]       gnt;
  logic             err;

  int total = 0;
  int bad   = 0;

  dcb_alloc #(.NN(5), .MN(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .fire  (fire),
    .eof   (eof),
    .cfg   (cfg),
    .gnt   (gnt),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Structural invariants of the configuration matrix.
  task automatic inv();
    logic       viol;
    logic [4:0] col_or;
    viol   = 1'b0;
    col_or = '0;
    for (int i = 0; i < 5; i++) begin
      if ($countones(cfg[i]) > 1) viol = 1'b1;
      col_or = col_or | cfg[i];
    end
    for (int j = 0; j < 5; j++) begin
      int n;
      n = 0;
      for (int i = 0; i < 5; i++) n += int'(cfg[i][j]);
      if (n > 1) viol = 1'b1;
    end
    chk("inv_rowcol", {31'd0, viol}, 32'd0);
    chk("inv_gnt", {27'd0, gnt}, {27'd0, col_or});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    inv();
  endtask

  task automatic do_reset();
    req  = '0;
    fire = '0;
    eof  = '0;
    rst_n = 1'b0;
    #2;
    chk("rst_cfg", {7'd0, cfg}, 32'd0);
    chk("rst_gnt", {27'd0, gnt}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [4:0] exp_seq [6];
    rst_n = 1'b1;
    req   = '0;
    fire  = '0;
    eof   = '0;
    #1;

    // Basic grant and release
    do_reset();
    req[2] = 5'b00100;
    tick();
    chk("basic_cfg2", {27'd0, cfg[2]}, 32'b00100);
    chk("basic_gnt", {27'd0, gnt}, 32'b00100);
    fire[2] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("basic_hold", {27'd0, cfg[2]}, 32'b00100);
    end
    eof[2] = 1'b1;
    req[2] = '0;
    tick();
    chk("basic_rel_cfg", {7'd0, cfg}, 32'd0);
    chk("basic_rel_gnt", {27'd0, gnt}, 32'd0);
    fire = '0;
    eof  = '0;
    tick();
    chk("basic_err", {31'd0, err}, 32'd0);

    // Round-robin fairness on output 4
    do_reset();
    req[0] = 5'b10000;
    req[1] = 5'b10000;
    req[3] = 5'b10000;
    exp_seq = '{5'b00001, 5'b00010, 5'b01000, 5'b00001, 5'b00010, 5'b01000};
    for (int g = 0; g < 6; g++) begin
      tick();
      chk("rr_grant", {27'd0, cfg[4]}, {27'd0, exp_seq[g]});
      fire = exp_seq[g];
      eof  = exp_seq[g];
      tick();
      chk("rr_bubble", {27'd0, cfg[4]}, 32'd0);
      fire = '0;
      eof  = '0;
    end
    chk("rr_err", {31'd0, err}, 32'd0);

    // Parallel non-conflicting grants
    do_reset();
    req[0] = 5'b00010;
    req[1] = 5'b00001;
    req[4] = 5'b01000;
    tick();
    chk("par_cfg", {7'd0, cfg}, {7'd0, 5'b00000, 5'b10000, 5'b00000, 5'b00001, 5'b00010});
    chk("par_gnt", {27'd0, gnt}, 32'b10011);
    chk("par_err", {31'd0, err}, 32'd0);

    // Lock hold
    do_reset();
    req[2] = 5'b00001;
    tick();
    chk("lock_own", {27'd0, cfg[0]}, 32'b00100);
    req[2] = '0;
    req[3] = 5'b00001;
    tick();
    chk("lock_hold1", {27'd0, cfg[0]}, 32'b00100);
    tick();
    chk("lock_hold2", {27'd0, cfg[0]}, 32'b00100);
    fire[2] = 1'b1;
    eof[2]  = 1'b1;
    tick();
    chk("lock_bubble", {27'd0, cfg[0]}, 32'd0);
    fire = '0;
    eof  = '0;
    tick();
    chk("lock_next", {27'd0, cfg[0]}, 32'b01000);
    chk("lock_err", {31'd0, err}, 32'd0);

    // Protocol errors: multi-hot request
    do_reset();
    req[1] = 5'b00011;
    tick();
    chk("err_mh_flag", {31'd0, err}, 32'd1);
    chk("err_mh_gnt", {27'd0, gnt}, 32'd0);
    tick();
    chk("err_mh_cfg", {7'd0, cfg}, 32'd0);
    req = '0;
    tick();
    chk("err_sticky", {31'd0, err}, 32'd1);

    // Protocol errors: fire without ownership
    do_reset();
    fire[0] = 1'b1;
    tick();
    chk("err_fire", {31'd0, err}, 32'd1);
    fire = '0;
    tick();
    tick();
    chk("err_fire_sticky", {31'd0, err}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("err_clr", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset mid-packet; ptr[3] must return to 0 so input 1 wins again
    do_reset();
    req[1] = 5'b01000;
    req[3] = 5'b01000;
    tick();
    chk("ar_own", {27'd0, cfg[3]}, 32'b00010);
    fire[1] = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_cfg", {7'd0, cfg}, 32'd0);
    chk("ar_gnt", {27'd0, gnt}, 32'd0);
    fire = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ar_regrant", {27'd0, cfg[3]}, 32'b00010);
    chk("ar_err", {31'd0, err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
